// File: rtl/mem_stage_rd_dp4.sv
// mem_stage_rd_dp4
//   4-lane read-permuting memory stage. Each lane writes a 4-word block in
//   natural order into one of two ping-pong banks. It then reads that block
//   back through a fixed per-lane index permutation, brev(t) XOR lane.
//   Back-to-back blocks stream at full rate: one bank is written while the
//   other bank is read.
//
//   Optional build macro MEM_STAGE_RD_OUT_REG_EN adds one output register
//   stage on every output. This raises the latency from 5 to 6 cycles.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous active-low reset
//   in_start            1-cycle pulse on cycle 0 of a 4-cycle input block
//   in_data_0..3        lane input words
//   out_data_0..3       lane permuted output words (hold when not valid)
//   out_start           1-cycle pulse on output cycle 0 of a block
//   out_valid           high on all 4 output cycles of a block
module mem_stage_rd_dp4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic [DATA_WIDTH-1:0] in_data_3,
  output logic [DATA_WIDTH-1:0] out_data_0,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic [DATA_WIDTH-1:0] out_data_3,
  output logic                  out_start,
  output logic                  out_valid
);

  typedef enum logic { IDLE,  WRITE } wstate_t;
  typedef enum logic { RIDLE, READ  } rstate_t;

  wstate_t               wstate;
  logic [1:0]            wcnt;
  logic                  wbank;
  rstate_t               rstate;
  logic [1:0]            rcnt;
  logic                  rbank;

  logic [DATA_WIDTH-1:0] mem   [4][8];
  logic [DATA_WIDTH-1:0] din   [4];
  logic [2:0]            raddr [4];
  logic [DATA_WIDTH-1:0] rd_q  [4];
  logic                  rd_valid_q;
  logic                  rd_start_q;

  logic                  we;
  logic [1:0]            widx;
  logic                  blk_done;
  logic                  done_bank;

  always_comb begin
    din[0] = in_data_0;
    din[1] = in_data_1;
    din[2] = in_data_2;
    din[3] = in_data_3;
  end

  // Word 0 is written on the in_start cycle itself, while still in IDLE.
  // blk_done is decoded on the last write cycle. READ is therefore active
  // on the following cycle.
  always_comb begin
    we        = (wstate == IDLE && in_start) || (wstate == WRITE);
    widx      = (wstate == WRITE) ? wcnt : 2'd0;
    blk_done  = (wstate == WRITE) && (wcnt == 2'd3);
    done_bank = wbank;
  end

  always_comb begin
    for (int unsigned l = 0; l < 4; l++)
      raddr[l] = {rbank, {rcnt[0], rcnt[1]} ^ 2'(l)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate <= IDLE;
      wcnt   <= '0;
      wbank  <= 1'b0;
    end else begin
      case (wstate)
        IDLE: begin
          if (in_start) begin
            wstate <= WRITE;
            wcnt   <= 2'd1;
          end
        end
        WRITE: begin
          if (wcnt == 2'd3) begin
            wstate <= IDLE;
            wcnt   <= '0;
            wbank  <= ~wbank;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        default: wstate <= IDLE;
      endcase
    end
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      for (int unsigned l = 0; l < 4; l++)
        mem[l][{wbank, widx}] <= din[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate     <= RIDLE;
      rcnt       <= '0;
      rbank      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_start_q <= 1'b0;
      for (int unsigned l = 0; l < 4; l++)
        rd_q[l] <= '0;
    end else begin
      rd_valid_q <= (rstate == READ);
      rd_start_q <= (rstate == READ) && (rcnt == 2'd0);
      if (rstate == READ) begin
        for (int unsigned l = 0; l < 4; l++)
          rd_q[l] <= mem[l][raddr[l]];
      end
      case (rstate)
        RIDLE: begin
          if (blk_done) begin
            rstate <= READ;
            rcnt   <= '0;
            rbank  <= done_bank;
          end
        end
        READ: begin
          rcnt <= rcnt + 2'd1;
          if (rcnt == 2'd3) begin
            // A block completing on the last read cycle chains directly.
            if (blk_done) rbank  <= done_bank;
            else          rstate <= RIDLE;
          end
        end
        default: rstate <= RIDLE;
      endcase
    end
  end

`ifdef MEM_STAGE_RD_OUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_start  <= 1'b0;
      out_data_0 <= '0;
      out_data_1 <= '0;
      out_data_2 <= '0;
      out_data_3 <= '0;
    end else begin
      out_valid  <= rd_valid_q;
      out_start  <= rd_start_q;
      out_data_0 <= rd_q[0];
      out_data_1 <= rd_q[1];
      out_data_2 <= rd_q[2];
      out_data_3 <= rd_q[3];
    end
  end
`else
  assign out_valid  = rd_valid_q;
  assign out_start  = rd_start_q;
  assign out_data_0 = rd_q[0];
  assign out_data_1 = rd_q[1];
  assign out_data_2 = rd_q[2];
  assign out_data_3 = rd_q[3];
`endif

endmodule
